// File: rtl/regfile_write_arbiter.sv
// Two-source arbiter for the single register-file write port. Each source has a
// one-entry holding buffer; the older buffer wins and equal ages go round-robin.
module regfile_write_arbiter (
   input  logic        clock,
   input  logic        ctrl_reset,
   input  logic        a_valid,
   input  logic [4:0]  a_reg,
   input  logic [31:0] a_data,
   output logic        a_ready,
   input  logic        b_valid,
   input  logic [4:0]  b_reg,
   input  logic [31:0] b_data,
   output logic        b_ready,
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        busy
);

   typedef enum logic [1:0] {AGE_EQ, AGE_A_OLD, AGE_B_OLD} age_e;

   logic        bufa_v_q, bufa_v_d, bufb_v_q, bufb_v_d;
   logic [4:0]  bufa_reg_q, bufa_reg_d, bufb_reg_q, bufb_reg_d;
   logic [31:0] bufa_data_q, bufa_data_d, bufb_data_q, bufb_data_d;
   age_e        age_q, age_d;
   logic        rr_q, rr_d;          // 0 = A, 1 = B
   logic        we_q, we_d;
   logic [4:0]  wreg_q, wreg_d;
   logic [31:0] wdata_q, wdata_d;

   logic        grant_a, grant_b, acc_a, acc_b, issue;
   logic [4:0]  win_reg;
   logic [31:0] win_data;

   // Grant depends only on buffer state, so ready never sees a valid input.
   assign grant_a = bufa_v_q & (~bufb_v_q | (age_q == AGE_A_OLD) |
                                ((age_q == AGE_EQ) & ~rr_q));
   assign grant_b = bufb_v_q & ~grant_a;

   assign a_ready = ~bufa_v_q | grant_a;
   assign b_ready = ~bufb_v_q | grant_b;

   assign ctrl_writeEnable = we_q;
   assign ctrl_writeReg    = wreg_q;
   assign data_writeReg    = wdata_q;
   assign busy             = bufa_v_q | bufb_v_q | we_q;

   always_comb begin
      acc_a       = a_valid & a_ready;
      acc_b       = b_valid & b_ready;
      bufa_v_d    = acc_a | (bufa_v_q & ~grant_a);
      bufb_v_d    = acc_b | (bufb_v_q & ~grant_b);
      bufa_reg_d  = acc_a ? a_reg  : bufa_reg_q;
      bufa_data_d = acc_a ? a_data : bufa_data_q;
      bufb_reg_d  = acc_b ? b_reg  : bufb_reg_q;
      bufb_data_d = acc_b ? b_data : bufb_data_q;

      // A lone load next to a surviving buffer makes the survivor older.
      age_d = age_q;
      if (!(bufa_v_d && bufb_v_d)) age_d = AGE_EQ;
      else if (acc_a && acc_b)     age_d = AGE_EQ;
      else if (acc_a)              age_d = AGE_B_OLD;
      else if (acc_b)              age_d = AGE_A_OLD;

      rr_d = rr_q;
      if (bufa_v_q && bufb_v_q && (age_q == AGE_EQ)) rr_d = grant_a;

      win_reg  = grant_a ? bufa_reg_q  : bufb_reg_q;
      win_data = grant_a ? bufa_data_q : bufb_data_q;
      issue    = (grant_a | grant_b) & (win_reg != 5'd0);
      we_d     = issue;
      wreg_d   = issue ? win_reg  : wreg_q;
      wdata_d  = issue ? win_data : wdata_q;
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         bufa_v_q    <= 1'b0;
         bufb_v_q    <= 1'b0;
         bufa_reg_q  <= '0;
         bufa_data_q <= '0;
         bufb_reg_q  <= '0;
         bufb_data_q <= '0;
         age_q       <= AGE_EQ;
         rr_q        <= 1'b0;
         we_q        <= 1'b0;
         wreg_q      <= '0;
         wdata_q     <= '0;
      end else begin
         bufa_v_q    <= bufa_v_d;
         bufb_v_q    <= bufb_v_d;
         bufa_reg_q  <= bufa_reg_d;
         bufa_data_q <= bufa_data_d;
         bufb_reg_q  <= bufb_reg_d;
         bufb_data_q <= bufb_data_d;
         age_q       <= age_d;
         rr_q        <= rr_d;
         we_q        <= we_d;
         wreg_q      <= wreg_d;
         wdata_q     <= wdata_d;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: issue order, ages, reg-0 drop, reset flush.
module tb_regfile_write_arbiter;

   logic        clock = 1'b0;
   logic        ctrl_reset;
   logic        a_valid, b_valid;
   logic [4:0]  a_reg, b_reg;
   logic [31:0] a_data, b_data;
   logic        a_ready, b_ready;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [4:0]  q_reg[$];
   logic [31:0] q_data[$];
   int          q_cyc[$];
   logic [31:0] rf[32];

   regfile_write_arbiter dut (
      .clock(clock), .ctrl_reset(ctrl_reset),
      .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Register-file model plus issue log.
   always @(negedge clock) begin
      if (!ctrl_reset && ctrl_writeEnable) begin
         q_reg.push_back(ctrl_writeReg);
         q_data.push_back(data_writeReg);
         q_cyc.push_back(cyc);
         rf[ctrl_writeReg] = data_writeReg;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic clrq();
      q_reg.delete();
      q_data.delete();
      q_cyc.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rdy;
      logic [4:0]  exp_reg[5];
      logic [31:0] exp_dat[5];
      int          ia;
      bit          bdone, acca, accb;

      for (int i = 0; i < 32; i++) rf[i] = '0;
      a_reg = '0; a_data = '0; b_reg = '0; b_data = '0;
      idle();
      ctrl_reset = 1'b1;
      repeat (2) step();
      ctrl_reset = 1'b0;

      // Reset state
      chk("rst_we",    32'(ctrl_writeEnable), 0);
      chk("rst_reg",   32'(ctrl_writeReg), 0);
      chk("rst_data",  data_writeReg, 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_ardy",  32'(a_ready), 1);
      chk("rst_brdy",  32'(b_ready), 1);

      // Single write latency
      a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hAA;
      #1 chk("t1_ardy", 32'(a_ready), 1);
      step();
      idle();
      chk("t1_we_n1",  32'(ctrl_writeEnable), 0);
      chk("t1_busy_n1", 32'(busy), 1);
      step();
      chk("t1_we_n2",  32'(ctrl_writeEnable), 1);
      chk("t1_reg",    32'(ctrl_writeReg), 5);
      chk("t1_data",   data_writeReg, 32'hAA);
      step();
      chk("t1_we_off", 32'(ctrl_writeEnable), 0);
      chk("t1_busy",   32'(busy), 0);

      // Simultaneous offers twice: round-robin alternates
      for (int r = 0; r < 2; r++) begin
         clrq();
         a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
         b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h22;
         #1;
         chk("t2_ardy", 32'(a_ready), 1);
         chk("t2_brdy", 32'(b_ready), 1);
         step();
         idle();
         repeat (4) step();
         chk("t2_cnt", 32'(q_reg.size()), 2);
         if (q_reg.size() == 2) begin
            chk("t2_first",  32'(q_reg[0]), (r == 0) ? 3 : 4);
            chk("t2_second", 32'(q_reg[1]), (r == 0) ? 4 : 3);
            chk("t2_b2b",    32'(q_cyc[1] - q_cyc[0]), 1);
         end
      end

      // A streams regs 1..4, B joins with reg 7 in the third cycle
      clrq();
      rdy = '0; ia = 0; bdone = 0;
      for (int c = 0; c < 8; c++) begin
         a_valid = (ia < 4); a_reg = 5'(ia + 1); a_data = 32'h100 + 32'(ia);
         b_valid = (c >= 2) && !bdone; b_reg = 5'd7; b_data = 32'h77;
         #1;
         rdy[c] = a_ready;
         acca = a_valid && a_ready;
         accb = b_valid && b_ready;
         step();
         if (acca) ia++;
         if (accb) bdone = 1;
      end
      idle();
      repeat (3) step();
      exp_reg = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd4};
      exp_dat = '{32'h100, 32'h101, 32'h102, 32'h77, 32'h103};
      chk("t3_a_all",  32'(ia), 4);
      chk("t3_rdy",    32'(rdy), 32'hEF);
      chk("t3_cnt",    32'(q_reg.size()), 5);
      if (q_reg.size() == 5)
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_reg%0d", i), 32'(q_reg[i]), 32'(exp_reg[i]));
            chk($sformatf("t3_dat%0d", i), q_data[i], exp_dat[i]);
         end

      // Write to reg 0 is accepted but never issued
      clrq();
      b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
      #1 chk("t4_brdy", 32'(b_ready), 1);
      step();
      idle();
      chk("t4_busy_held", 32'(busy), 1);
      repeat (3) step();
      chk("t4_cnt",  32'(q_reg.size()), 0);
      chk("t4_reg",  32'(ctrl_writeReg), 4);
      chk("t4_data", data_writeReg, 32'h103);
      chk("t4_busy", 32'(busy), 0);

      // Same-register ordering with A held back by reg 8 traffic
      b_valid = 1'b1; b_reg = 5'd8; b_data = 32'h81;
      step();
      a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h1;
      b_valid = 1'b1; b_reg = 5'd8; b_data = 32'h82;
      #1;
      chk("t5_ardy", 32'(a_ready), 1);
      chk("t5_brdy", 32'(b_ready), 1);
      step();
      a_valid = 1'b0;
      b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h2;
      #1;
      chk("t5_ablk", 32'(a_ready), 0);
      chk("t5_brdy2", 32'(b_ready), 1);
      step();
      idle();
      repeat (4) step();
      chk("t5_rf9", rf[9], 32'h2);
      chk("t5_rf8", rf[8], 32'h82);

      // Reset with both buffers full
      a_valid = 1'b1; a_reg = 5'd10; a_data = 32'h10A;
      b_valid = 1'b1; b_reg = 5'd11; b_data = 32'h10B;
      step();
      idle();
      clrq();
      ctrl_reset = 1'b1;
      step();
      ctrl_reset = 1'b0;
      chk("t6_ardy", 32'(a_ready), 1);
      chk("t6_brdy", 32'(b_ready), 1);
      chk("t6_we",   32'(ctrl_writeEnable), 0);
      chk("t6_busy", 32'(busy), 0);
      repeat (3) step();
      chk("t6_cnt",  32'(q_reg.size()), 0);
      chk("t6_rf10", rf[10], 0);
      chk("t6_rf11", rf[11], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the single register-file write port between two writeback sources: port A (ALU/main pipeline) and port B (multdiv unit). Each source has a one-entry holding buffer, so a source can hand off a write without waiting for the port. The older buffered write wins. Writes buffered on the same cycle are decided by a round-robin pointer. The winner drives a registered write (enable, register number, data) that feeds the register file's `ctrl_writeEnable`, `ctrl_writeReg` and `data_writeReg` inputs. Writes to register 0 complete their handshake but are never issued.

## Interface
- No parameters. Data width is 32 and the register-number width is 5, both fixed.
- `clock`  input  1  Single clock. All state updates on the rising edge.
- `ctrl_reset`  input  1  Synchronous, active-high reset.
- `a_valid`  input  1  Port A offers a write this cycle.
- `a_reg`  input  5  Port A destination register.
- `a_data`  input  32  Port A write data.
- `a_ready`  output  1  Port A write is accepted at this edge if `a_valid` is also high.
- `b_valid`, `b_reg`, `b_data`, `b_ready`  Same definitions as port A, for port B.
- `ctrl_writeEnable`  output  1  Registered write enable to the register file.
- `ctrl_writeReg`  output  5  Registered destination register.
- `data_writeReg`  output  32  Registered write data.
- `busy`  output  1  High when either holding buffer is occupied or `ctrl_writeEnable` is high. Used for drain/stall decisions.

## Operation
- Holding buffers:
  - Each port has `bufX_valid`, `bufX_reg` and `bufX_data`.
  - The accept condition for port X is `X_valid & X_ready`.
  - `X_ready = ~bufX_valid | grantX`, which allows a same-cycle drain and refill.
- Grant is computed combinationally, only from buffer state, the age flag and the pointer. There is no combinational path from any `*_valid` input to any `*_ready` output.
  - Only bufA valid: grant A.
  - Only bufB valid: grant B.
  - Both valid with different ages: grant the older buffer.
  - Both valid with equal age: grant the port named by `rr_ptr`.
- Age tracking:
  - When a buffer is loaded while the other buffer stays occupied and is not granted, the occupied buffer becomes older.
  - When both buffers are loaded at the same edge, their ages are equal.
  - A same-cycle drain and refill of one buffer makes the other occupied buffer older.
- `rr_ptr` after reset points to A. It updates only on an equal-age tie and then points to the loser.
- Exactly one grant per cycle. The granted buffer drains at the edge, unless it refills at the same edge.
- Output register load at each edge:
  - If there is a grant with a nonzero register: `ctrl_writeEnable` = 1, and `ctrl_writeReg`/`data_writeReg` take the winner's register and data.
  - Otherwise, including a grant to register 0: `ctrl_writeEnable` = 0. `ctrl_writeReg` and `data_writeReg` hold their previous values.
- Same-register ordering: the age rule guarantees that writes to one register from A and B land in acceptance order. Writes accepted in the same cycle land in `rr_ptr` order. Sources must not rely on any other order.

## Timing
- Reset values: both buffers invalid, age equal, `rr_ptr` = A, `ctrl_writeEnable` = 0, `ctrl_writeReg` = 0, `data_writeReg` = 0, `busy` = 0. With both buffers empty, `a_ready` and `b_ready` are 1, including the first cycle after reset.
- Reset mid-operation discards buffered writes and any pending output write. Nothing is issued after `ctrl_reset` is sampled high. Inputs are ignored while reset is high.
- Latency:
  - A write accepted at edge N sits in the buffer during cycle N+1.
  - With no contention it is granted in cycle N+1 and appears on the outputs with `ctrl_writeEnable` = 1 after edge N+1.
  - The register file captures it at edge N+2.
- Throughput: 1 issued write per cycle total. Each port can sustain 1 accept per cycle while it keeps winning.
- A losing buffer waits at most 1 cycle. It is older at the next decision, or `rr_ptr` favours it, so there is no starvation.
- `ctrl_writeEnable` is high for exactly one cycle per issued write. Back-to-back writes produce consecutive high cycles.

## Test plan
- Reset, then A offers reg 5 with data 0x0000_00AA for one cycle:
  - `a_ready` = 1.
  - `ctrl_writeEnable` is high exactly 2 cycles after the accept edge's cycle, with reg 5 and data 0xAA.
  - `busy` returns to 0 afterwards.
- A and B both offer in the same cycle (A: reg 3, data 0x11; B: reg 4, data 0x22):
  - Issue order is A then B on consecutive cycles.
  - Repeat the same test: order is B then A, because `rr_ptr` alternates.
- A is held valid for 4 cycles (regs 1–4) while B offers reg 7 in cycle 2:
  - B issues immediately after the A write that was older than it.
  - No A write is lost.
  - `a_ready` deasserts for exactly the cycle A loses.
- B offers reg 0 with data 0xFFFF_FFFF:
  - `b_ready` = 1 and the handshake completes.
  - `ctrl_writeEnable` never asserts.
  - `ctrl_writeReg` and `data_writeReg` keep their prior values.
- Same-register ordering: A writes reg 9 with 0x1, then B writes reg 9 with 0x2 one cycle later, while A is kept blocked by traffic to reg 8:
  - A reg-file model reads reg 9 = 0x2 at the end.
- Assert `ctrl_reset` for one cycle while both buffers are full:
  - The next cycle shows both `*_ready` = 1, `ctrl_writeEnable` = 0 and `busy` = 0.
  - No buffered write is ever issued.
